// File: rtl/mux_arbiter4.sv
// Round-robin arbiter driving the select of a shared 4:1 mux; one idle cycle between owners.
// Optional hold timeout is enabled by defining ARB_TIMEOUT_EN.
module mux_arbiter4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] req_i,
  input  logic       release_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic       timeout_q, timeout_d;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       normal_exit;
  logic       force_exit;

  // Scan from ptr+4 down to ptr+1 so the earliest position in round-robin order is assigned last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // In OWN, sel_q is the owner's index.
  assign normal_exit = release_i | ~req_i[sel_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;

  assign force_exit = ~normal_exit && (hold_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == S_IDLE) begin
      hold_d = '0;
    end else if (hold_q != {CNT_W{1'b1}}) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_HOLD[0], CNT_W[0]};
  assign force_exit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    if (state_q == S_IDLE) begin
      grant_d = 4'b0000;
      if (win_vld) begin
        state_d = S_OWN;
        grant_d = 4'b0001 << win_idx;
        sel_d   = win_idx;
        ptr_d   = win_idx;
      end
    end else if (normal_exit || force_exit) begin
      state_d   = S_IDLE;
      grant_d   = 4'b0000;
      timeout_d = force_exit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'b11;
      sel_q     <= 2'b00;
      grant_q   <= 4'b0000;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign sel_o     = sel_q;
  assign busy_o    = (state_q == S_OWN);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mux_arbiter4.sv
// Bench for mux_arbiter4: directed scenarios plus random traffic against an owner/pointer reference model.
module tb_mux_arbiter4;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  mux_arbiter4 #(.MAX_HOLD(MAXH), .CNT_W(4)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .req_i    (req),
    .release_i(rel),
    .grant_o  (grant),
    .sel_o    (sel),
    .busy_o   (busy),
    .timeout_o(timeout)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: current owner (-1 = none), last winner, select, cycles the grant has been visible.
  int m_owner = -1;
  int m_last  = 3;
  int m_sel   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic [3:0] rq, input logic rl);
    bit timeout_on;
`ifdef ARB_TIMEOUT_EN
    timeout_on = 1'b1;
`else
    timeout_on = 1'b0;
`endif
    m_to = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_last  = 3;
      m_sel   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (rq[idx]) begin
          m_owner = idx;
          m_last  = idx;
          m_sel   = idx;
          m_held  = 1;
          break;
        end
      end
    end else if (rl || !rq[m_owner]) begin
      m_owner = -1;
    end else if (timeout_on && m_held >= MAXH) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] rq, input logic rl);
    reset = rst;
    req   = rq;
    rel   = rl;
    @(posedge clk);
    model_step(rst, rq, rl);
    cyc++;
    #1;
    check("grant",   {28'd0, grant},   (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("sel",     {30'd0, sel},     m_sel);
    check("busy",    {31'd0, busy},    (m_owner >= 0) ? 32'd1 : 32'd0);
    check("timeout", {31'd0, timeout}, {31'd0, m_to});
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    rel   = 1'b0;

    // Reset with all requests pending: outputs stay zero.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    check("rst_grant", {28'd0, grant}, 32'd0);
    step(1'b0, 4'b1111, 1'b0);
    check("first_grant", {28'd0, grant}, 32'h1);
    check("first_sel",   {30'd0, sel},   32'd0);

    // Full rotation with one release per grant.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b1111, 1'b1);
      check("rot_gap", {28'd0, grant}, 32'd0);
      step(1'b0, 4'b1111, 1'b0);
      check("rot_grant", {28'd0, grant}, 32'd1 << ((i + 1) % 4));
      check("rot_sel",   {30'd0, sel},   (i + 1) % 4);
    end

    // Single requester re-served after one idle cycle.
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    check("solo_grant", {28'd0, grant}, 32'h4);
    step(1'b0, 4'b0100, 1'b1);
    check("solo_idle_sel", {30'd0, sel}, 32'd2);
    step(1'b0, 4'b0100, 1'b0);
    check("solo_regrant", {28'd0, grant}, 32'h4);

    // Owner 3 drops its request without release.
    step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    check("own3_grant", {28'd0, grant}, 32'h8);
    step(1'b0, 4'b0000, 1'b0);
    check("drop_grant", {28'd0, grant}, 32'd0);
    check("drop_sel",   {30'd0, sel},   32'd3);

    // Long hold: timeout behaviour or indefinite ownership, depending on build.
    for (int i = 0; i < 21; i++) step(1'b0, 4'b0011, 1'b0);

    // Reset mid-ownership restores the priority pointer.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    check("pre_rst_grant", {28'd0, grant}, 32'h8);
    step(1'b1, 4'b1000, 1'b0);
    check("mid_rst_grant", {28'd0, grant}, 32'd0);
    check("mid_rst_sel",   {30'd0, sel},   32'd0);
    step(1'b0, 4'b1001, 1'b0);
    check("post_rst_grant", {28'd0, grant}, 32'h1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'd0;
      step(($urandom_range(0, 99) == 0), r, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
